ecg_buf_writer: RTL and testbench
=================================

ECG_BUF_WRITER -- requirements
Module: ecg_buf_writer

Interface
REQ-001 Parameter ADDR_W, default 12, per-bank address width.
REQ-002 Parameter DATA_W, default 12, sample width.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load  input  ADDR_W  frame length in samples; sampled only when a new frame starts.
REQ-006 s_valid  input  1  incoming sample strobe.
REQ-007 s_data  input  DATA_W  incoming ECG sample.
REQ-008 s_ready  output  1  high when a sample presented with s_valid is accepted this cycle.
REQ-009 rd_switch  input  1  bank-consumed toggle from the downstream reader; each level change means one bank has been released.
REQ-010 wea  output  1  BRAM write enable.
REQ-011 addr  output  ADDR_W+1  BRAM write address {bank, offset}.
REQ-012 dina  output  DATA_W  BRAM write data.
REQ-013 frame_rdy  output  1  one-cycle pulse when a full bank is handed to the reader.
REQ-014 bank  output  1  bank currently being written.
REQ-015 ovf  output  1  sticky overflow flag.

Function
REQ-016 FSM states SHALL be IDLE, FILL, HANDOFF, WAIT.
REQ-017 IDLE: capture frame length L = max(load, 2), offset = 0, go to FILL next cycle; s_ready low.
REQ-018 FILL: s_ready high; on s_valid, register wea=1, addr={bank, offset}, dina=s_data, offset+1, so write reaches BRAM one cycle after acceptance.
REQ-019 FILL: when the sample written at offset L-1 is accepted, go to HANDOFF; offset does not increment past L-1.
REQ-020 HANDOFF: s_ready low; if reader credit is available, consume it, toggle bank, pulse frame_rdy, go to IDLE; else go to WAIT.
REQ-021 Reader credit: 1-bit flag, set on detected rd_switch edge (rd_switch != registered copy), cleared when consumed; credit set and consumed in the same cycle leaves it clear.
REQ-022 At reset credit SHALL be 1 (both banks free at start).
REQ-023 WAIT: s_ready low; samples arriving with s_valid SHALL be dropped and set ovf; exit to HANDOFF-action (toggle, pulse, IDLE) on first cycle credit is available.
REQ-024 A second rd_switch edge while credit is already set SHALL be ignored and set ovf (reader over-release).
REQ-025 wea SHALL be low in every cycle with no accepted sample.
REQ-026 load changes during FILL/WAIT SHALL not affect the current frame.
REQ-027 ovf clears only on reset.

Reset
REQ-028 On rst: state IDLE, offset 0, bank 0, wea 0, addr 0, dina 0, frame_rdy 0, ovf 0, credit 1, rd_switch copy loaded with current rd_switch.
REQ-029 rst mid-frame SHALL discard the partial frame with no frame_rdy pulse.

Configuration
REQ-030 Macro ECG_BUF_OVF_CNT_EN defined: extra output ovf_cnt (16 bit) counting dropped samples, saturating at 16'hFFFF, cleared on reset.
REQ-031 Macro undefined: no ovf_cnt port or counter; ovf flag behaviour unchanged.

Structure
REQ-032 Shared package ecg_buf_pkg SHALL hold state enum type, default ADDR_W/DATA_W constants, and minimum frame length constant 2.
REQ-033 One sub-module ecg_edge_toggle (rd_switch edge detector + credit flag) is natural; rest is flat.

Verification
REQ-034 load=8, continuous s_valid data 1..8 -> wea on addr 0x000..0x007 with dina 1..8, one frame_rdy, bank becomes 1.
REQ-035 load=4, second frame with no rd_switch edge, 3 extra samples -> WAIT, s_ready low, ovf=1, ovf_cnt=3 when macro on; toggle rd_switch -> frame_rdy within 1 cycle, bank 0.
REQ-036 load=0 and load=1 -> frame of exactly 2 samples at offsets 0,1.
REQ-037 load changed from 8 to 3 at offset 5 -> current frame still ends at offset 7; next frame length 3.
REQ-038 rst asserted at offset 5 -> next writes restart at addr 0x000, no frame_rdy, ovf 0.
REQ-039 Two rd_switch edges with credit already set -> ovf=1, only one later handoff proceeds without WAIT.

Source files
------------

// File: rtl/ecg_buf_pkg.sv
// Shared types and constants for the ECG sample buffer writer.
package ecg_buf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        HANDOFF = 2'd2,
        WAIT    = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 12;

    localparam int unsigned MIN_FRAME_LEN = 2;

endpackage

// File: rtl/ecg_edge_toggle.sv
// Reader release tracking: detects rd_switch level changes and keeps a one-bank credit flag.
module ecg_edge_toggle (
    input  logic clk,
    input  logic rst,
    input  logic rd_switch,
    input  logic consume,
    output logic credit_avail,
    output logic over_release
);

    logic rd_q;
    logic credit;
    logic toggled;

    always_comb begin
        toggled      = rd_switch ^ rd_q;
        // A release seen this cycle can be spent in the same cycle
        credit_avail = credit | toggled;
        over_release = credit & toggled;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= rd_switch;
            credit <= 1'b1;
        end else begin
            rd_q   <= rd_switch;
            credit <= credit_avail & ~consume;
        end
    end

endmodule

// File: rtl/ecg_buf_writer.sv
// Double-buffered ECG frame writer into a banked BRAM with reader handoff.
// Optional ECG_BUF_OVF_CNT_EN adds a saturating dropped-sample counter output.
module ecg_buf_writer
    import ecg_buf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] load,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              rd_switch,
    output logic              wea,
    output logic [ADDR_W:0]   addr,
    output logic [DATA_W-1:0] dina,
    output logic              frame_rdy,
    output logic              bank,
    output logic              ovf
`ifdef ECG_BUF_OVF_CNT_EN
    ,
    output logic [15:0]       ovf_cnt
`endif
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] offset;
    logic              credit_avail;
    logic              over_release;
    logic              accept;
    logic              last;
    logic              go;
    logic              drop;

    ecg_edge_toggle u_edge (
        .clk          (clk),
        .rst          (rst),
        .rd_switch    (rd_switch),
        .consume      (go),
        .credit_avail (credit_avail),
        .over_release (over_release)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FILL;
            FILL:    if (last) state_nxt = HANDOFF;
            HANDOFF: state_nxt = go ? IDLE : WAIT;
            WAIT:    if (go) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state == FILL);
        accept  = s_ready & s_valid;
        last    = accept & (offset == len - ADDR_W'(1));
        go      = ((state == HANDOFF) || (state == WAIT)) & credit_avail;
        drop    = (state == WAIT) & s_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len       <= ADDR_W'(MIN_FRAME_LEN);
            offset    <= '0;
            bank      <= 1'b0;
            wea       <= 1'b0;
            addr      <= '0;
            dina      <= '0;
            frame_rdy <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            wea       <= accept;
            frame_rdy <= go;
            if (state == IDLE) begin
                len    <= (load < ADDR_W'(MIN_FRAME_LEN)) ? ADDR_W'(MIN_FRAME_LEN) : load;
                offset <= '0;
            end
            if (accept) begin
                addr <= {bank, offset};
                dina <= s_data;
                if (!last) offset <= offset + ADDR_W'(1);
            end
            if (go) bank <= ~bank;
            if (drop || over_release) ovf <= 1'b1;
        end
    end

`ifdef ECG_BUF_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)                         ovf_cnt <= '0;
        else if (drop && ovf_cnt != '1)  ovf_cnt <= ovf_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ecg_buf_writer.sv
// Directed bench for ecg_buf_writer: vector table plus reset/load/credit corner sequences.
module tb_ecg_buf_writer;

    localparam int AW = 12;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] load;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          rd_switch;
    logic          wea;
    logic [AW:0]   addr;
    logic [DW-1:0] dina;
    logic          frame_rdy;
    logic          bank;
    logic          ovf;
`ifdef ECG_BUF_OVF_CNT_EN
    logic [15:0]   ovf_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ecg_buf_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .rd_switch (rd_switch),
        .wea       (wea),
        .addr      (addr),
        .dina      (dina),
        .frame_rdy (frame_rdy),
        .bank      (bank),
        .ovf       (ovf)
`ifdef ECG_BUF_OVF_CNT_EN
        ,
        .ovf_cnt   (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] load;
        logic          v;
        logic [DW-1:0] d;
        logic          rs;
        logic          e_rdy;
        logic          e_wea;
        logic [AW:0]   e_addr;
        logic [DW-1:0] e_dina;
        logic          e_fr;
        logic          e_bank;
        logic          e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int ld, input bit v, input int d, input bit rs, input bit rdy,
                       input bit w, input int a, input int di, input bit fr, input bit bk, input bit ov);
        vec_t r;
        r.load = AW'(ld); r.v = v; r.d = DW'(d); r.rs = rs; r.e_rdy = rdy; r.e_wea = w;
        r.e_addr = (AW+1)'(a); r.e_dina = DW'(di); r.e_fr = fr; r.e_bank = bk; r.e_ovf = ov;
        vecs.push_back(r);
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic send(input int d, input int exp_addr);
        s_valid = 1'b1;
        s_data  = DW'(d);
        check("send_s_ready", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        check("send_wea", 32'(wea), 32'd1);
        check("send_addr", 32'(addr), 32'(exp_addr));
        check("send_dina", 32'(dina), 32'(d));
    endtask

    initial begin
        rd_switch = 1'b0;
        load      = '0;
        do_reset();

        check("rst_wea", 32'(wea), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_dina", 32'(dina), 32'd0);
        check("rst_frame_rdy", 32'(frame_rdy), 32'd0);
        check("rst_bank", 32'(bank), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);

        // frame 1: load=8, data 1..8, initial credit lets it hand off at once
        add(8, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0);
        for (int i = 1; i <= 8; i++) add(8, 1, i, 0,  1, 1, i - 1, i,  0, 0, 0);
        add(8, 0, 0, 0,  0, 0, 0, 0,  1, 1, 0);
        // frame 2: load=4 into bank 1, no credit -> WAIT, 3 dropped samples
        add(4, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0);
        for (int k = 0; k < 4; k++) add(4, 1, 'h10 + k, 0,  1, 1, 'h1000 + k, 'h10 + k,  0, 1, 0);
        add(4, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0);
        for (int k = 0; k < 3; k++) add(4, 1, 'h55, 0,  0, 0, 0, 0,  0, 1, 1);
        add(4, 0, 0, 1,  0, 0, 0, 0,  1, 0, 1);
        // frame 3: load=0 -> two samples at offsets 0,1
        add(0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 1);
        add(0, 1, 'h21, 1,  1, 1, 'h000, 'h21,  0, 0, 1);
        add(0, 1, 'h22, 1,  1, 1, 'h001, 'h22,  0, 0, 1);
        add(0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 1);
        add(0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 1);

        foreach (vecs[i]) begin
            load = vecs[i].load; s_valid = vecs[i].v; s_data = vecs[i].d; rd_switch = vecs[i].rs;
            check($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].e_rdy));
            tick();
            check($sformatf("v%0d_wea", i), 32'(wea), 32'(vecs[i].e_wea));
            check($sformatf("v%0d_frame_rdy", i), 32'(frame_rdy), 32'(vecs[i].e_fr));
            check($sformatf("v%0d_bank", i), 32'(bank), 32'(vecs[i].e_bank));
            check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].e_ovf));
            if (vecs[i].e_wea) begin
                check($sformatf("v%0d_addr", i), 32'(addr), 32'(vecs[i].e_addr));
                check($sformatf("v%0d_dina", i), 32'(dina), 32'(vecs[i].e_dina));
            end
        end
        s_valid = 1'b0;
`ifdef ECG_BUF_OVF_CNT_EN
        check("tbl_ovf_cnt", 32'(ovf_cnt), 32'd3);
`endif

        // load changed mid-frame: current frame keeps length 8, next uses 3
        rd_switch = 1'b0;
        do_reset();
        load = 8;
        tick();
        for (int i = 0; i < 5; i++) send('h30 + i, i);
        load = 3;
        for (int i = 5; i < 8; i++) send('h30 + i, i);
        check("ld_handoff_s_ready", 32'(s_ready), 32'd0);
        tick();
        check("ld_frame_rdy", 32'(frame_rdy), 32'd1);
        check("ld_bank", 32'(bank), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) send('h40 + i, 'h1000 + i);
        check("ld3_end_s_ready", 32'(s_ready), 32'd0);

        // reset mid-frame discards the partial frame
        do_reset();
        load = 8;
        tick();
        for (int i = 0; i < 6; i++) send('h50 + i, i);
        s_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; s_valid = 1'b0;
        check("mrst_wea", 32'(wea), 32'd0);
        check("mrst_frame_rdy", 32'(frame_rdy), 32'd0);
        check("mrst_ovf", 32'(ovf), 32'd0);
        check("mrst_bank", 32'(bank), 32'd0);
        check("mrst_s_ready", 32'(s_ready), 32'd0);
`ifdef ECG_BUF_OVF_CNT_EN
        check("mrst_ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif
        tick();
        send('h60, 'h000);

        // over-release: two edges with credit already held, load=1 frames of 2
        rd_switch = 1'b0;
        do_reset();
        load = 1;
        rd_switch = 1'b1;
        tick();
        check("orel_ovf1", 32'(ovf), 32'd1);
        rd_switch = 1'b0;
        tick();
        check("orel_ovf2", 32'(ovf), 32'd1);
        send('h71, 'h000);
        send('h72, 'h001);
        check("orel_handoff_s_ready", 32'(s_ready), 32'd0);
        tick();
        check("orel_frame_rdy", 32'(frame_rdy), 32'd1);
        check("orel_bank", 32'(bank), 32'd1);
        tick();
        send('h73, 'h1000);
        send('h74, 'h1001);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("orel_wait_fr%0d", c), 32'(frame_rdy), 32'd0);
            check($sformatf("orel_wait_rdy%0d", c), 32'(s_ready), 32'd0);
        end
        check("orel_bank_hold", 32'(bank), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
